// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller.
// Segment codes are active-high, bit 0 = a .. bit 6 = g.
package ssd_pkg;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] seg_of(
    input logic [3:0] nib,
    input bit         active_low
  );
    return active_low ? ~SEG_CODE[nib] : SEG_CODE[nib];
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Nibble to seven-segment pattern, polarity chosen at build time.
// Purely combinational; one instance serves the muxed digit.
module ssd_hex_decode
  import ssd_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // look up the pattern and apply polarity
  assign seg = seg_of(nib, ACTIVE_LOW);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed hex display scanner: double-buffered value, blanking, blink.
// Build with SSD_LZB_EN defined to add leading-zero blanking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIV            = 50000,
  parameter int BLANK_CYC      = 16,
  parameter int BLINK_FRAMES   = 64,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic                    load,
  input  logic [N_DIGITS-1:0]     blink_mask,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] I_LAST  = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

  localparam logic [N_DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0] SEG_IDLE =
    SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] shadow;
  logic [4*N_DIGITS-1:0] display;
  logic                  pending;
  logic [FW-1:0]         fcnt;
  logic                  blink_phase;

  logic                  slot_end;
  logic                  boundary;
  logic [3:0]            nib;
  logic                  hide;
  logic                  off;
  logic [N_DIGITS-1:0]   onehot;
  logic [N_DIGITS-1:0]   lzb;
  logic [6:0]            dec_seg;

  assign slot_end = (prescaler == P_LAST);
  assign boundary = slot_end && (idx == I_LAST);

  // slot prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= slot_end ? '0 : prescaler + 1'b1;
      if (slot_end)
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end
  end

  // shadow capture and tear-free transfer at frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else begin
      if (boundary && pending) begin
        display <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

  // frame counter and blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (fcnt == F_LAST) begin
        fcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

`ifdef SSD_LZB_EN
  logic zrun;

  // a digit is dark while it and every higher digit are zero
  always_comb begin
    zrun = 1'b1;
    lzb  = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zrun   = zrun & (display[4*i +: 4] == 4'h0);
      lzb[i] = zrun;
    end
  end
`else
  assign lzb = '0;
`endif

  // select the active digit, its nibble and its blanking
  always_comb begin
    nib    = '0;
    hide   = 1'b0;
    onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = display[4*i +: 4];
        hide      = (blink_phase & blink_mask[i]) | lzb[i];
        onehot[i] = 1'b1;
      end
    end
  end

  assign off = (prescaler < P_BLANK) | hide;

  ssd_hex_decode #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= AN_OFF;
      seg        <= SEG_IDLE;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (off) begin
        an  <= AN_OFF;
        seg <= SEG_IDLE;
      end else begin
        an  <= AN_ACTIVE_LOW ? ~onehot : onehot;
        seg <= dec_seg;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl (4 digits, 8-cycle slots).
// Reference model derives outputs from the cycle count since reset.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  logic [6:0] codes [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [15:0] val;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs [12];

  ssd_scan_ctrl #(
    .N_DIGITS       (4),
    .DIV            (8),
    .BLANK_CYC      (1),
    .BLINK_FRAMES   (2),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic adv_to(input int t);
    while (cur < t) cyc();
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!frame_tick && n < 100);
    check("tick_wait", 32'(frame_tick), 32'd1);
    cur = 0;
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
  endtask

  // expected {an, seg, frame_tick} for combinational position k
  function automatic logic [11:0] model_out(input int k,
                                            input logic [15:0] d,
                                            input logic [3:0] mk);
    int p, ix, fr;
    bit ph, hide;
    logic [3:0] nib, an_e;
    logic [6:0] sg;
    p    = k % 8;
    ix   = (k / 8) % 4;
    fr   = k / 32;
    ph   = ((fr / 2) % 2) == 1;
    nib  = 4'((d >> (4 * ix)) & 16'hF);
    hide = (p < 1) || (ph && mk[ix]);
`ifdef SSD_LZB_EN
    if (ix != 0 && (d >> (4 * ix)) == 16'h0) hide = 1'b1;
`endif
    an_e = hide ? 4'hF : ~(4'b0001 << ix);
    sg   = hide ? 7'h00 : codes[nib];
    return {an_e, sg, (k % 32) == 31};
  endfunction

  initial begin
    logic [15:0] m_disp, m_shadow;
    bit          m_pend;
    logic [11:0] exp_o;
    bit          first;
    logic [15:0] cur_val;
    bit          blk [4];
    int          nblk, n;

    vecs[0]  = '{16'h12AF, 0, 4'b1110, 7'h71};
    vecs[1]  = '{16'h12AF, 1, 4'b1101, 7'h77};
    vecs[2]  = '{16'h12AF, 2, 4'b1011, 7'h5B};
    vecs[3]  = '{16'h12AF, 3, 4'b0111, 7'h06};
    vecs[4]  = '{16'hB9D4, 0, 4'b1110, 7'h66};
    vecs[5]  = '{16'hB9D4, 1, 4'b1101, 7'h5E};
    vecs[6]  = '{16'hB9D4, 2, 4'b1011, 7'h6F};
    vecs[7]  = '{16'hB9D4, 3, 4'b0111, 7'h7C};
    vecs[8]  = '{16'h0050, 0, 4'b1110, 7'h3F};
    vecs[9]  = '{16'h0050, 1, 4'b1101, 7'h6D};
`ifdef SSD_LZB_EN
    vecs[10] = '{16'h0050, 2, 4'b1111, 7'h00};
    vecs[11] = '{16'h0050, 3, 4'b1111, 7'h00};
`else
    vecs[10] = '{16'h0050, 2, 4'b1011, 7'h3F};
    vecs[11] = '{16'h0050, 3, 4'b0111, 7'h3F};
`endif

    // reset held with random inputs
    #3 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      value = 16'($urandom);
      load  = 1'($urandom);
      cyc();
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h0);
      check("rst_tick", 32'(frame_tick), 32'h0);
    end
    load  = 1'b0;
    rst_n = 1'b1;

    // random traffic against the reference model
    m_disp = '0;
    m_shadow = '0;
    m_pend = 1'b0;
    for (int k = 0; k < 800; k++) begin
      cyc();
      exp_o = model_out(k, m_disp, blink_mask);
      check("model", {20'h0, an, seg, frame_tick}, {20'h0, exp_o});
      if ((k % 32) == 31 && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (load) begin
        m_shadow = value;
        m_pend   = 1'b1;
      end
      value = 16'($urandom);
      load  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
    end
    load = 1'b0;
    blink_mask = '0;

    // table vectors
    first = 1'b1;
    cur_val = '0;
    for (int i = 0; i < 12; i++) begin
      if (first || vecs[i].val != cur_val) begin
        do_load(vecs[i].val);
        wait_tick();
        wait_tick();
        first = 1'b0;
        cur_val = vecs[i].val;
      end
      adv_to(8 * vecs[i].slot + 1);
      check("vec_gap_an", 32'(an), 32'hF);
      check("vec_gap_seg", 32'(seg), 32'h0);
      adv_to(8 * vecs[i].slot + 5);
      check("vec_an", 32'(an), 32'(vecs[i].an));
      check("vec_seg", 32'(seg), 32'(vecs[i].seg));
    end

    // load mid-frame, then load on the boundary
    do_load(16'h12AF);
    wait_tick();
    wait_tick();
    adv_to(9);
    do_load(16'h3333);
    adv_to(21);
    check("mid_s2_seg", 32'(seg), 32'h5B);
    adv_to(29);
    check("mid_s3_seg", 32'(seg), 32'h06);
    adv_to(32);
    check("mid_tick", 32'(frame_tick), 32'h1);
    cur = 0;
    adv_to(5);
    check("mid_next_an", 32'(an), 32'hE);
    check("mid_next_seg", 32'(seg), 32'h4F);
    adv_to(31);
    value = 16'h4444;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
    check("coin_tick", 32'(frame_tick), 32'h1);
    cur = 0;
    adv_to(5);
    check("coin_old_seg", 32'(seg), 32'h4F);
    adv_to(32);
    check("coin_tick2", 32'(frame_tick), 32'h1);
    cur = 0;
    adv_to(5);
    check("coin_new_seg", 32'(seg), 32'h66);

    // blink on digit 0 over four frames
    do_load(16'h12AF);
    wait_tick();
    wait_tick();
    blink_mask = 4'b0001;
    nblk = 0;
    for (int f = 0; f < 4; f++) begin
      adv_to(5);
      blk[f] = (an == 4'hF);
      if (blk[f]) nblk++;
      check("blink_d0_form",
            32'((an == 4'hF && seg == 7'h00) ||
                (an == 4'hE && seg == 7'h71)), 32'h1);
      adv_to(13);
      check("blink_d1_an", 32'(an), 32'hD);
      check("blink_d1_seg", 32'(seg), 32'h77);
      wait_tick();
    end
    check("blink_count", 32'(nblk), 32'd2);
    check("blink_alt02", 32'(blk[0] != blk[2]), 32'h1);
    check("blink_alt13", 32'(blk[1] != blk[3]), 32'h1);
    blink_mask = '0;

    // asynchronous reset in slot 2 with a load pending
    adv_to(3);
    do_load(16'h7777);
    adv_to(20);
    #1 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rel_first_an", 32'(an), 32'hF);
    cyc();
    check("rel_s0_an", 32'(an), 32'hE);
    check("rel_s0_seg", 32'(seg), 32'h3F);
    n = 2;
    while (!frame_tick && n < 100) begin
      cyc();
      n++;
    end
    check("rel_tick_lat", 32'(n), 32'd32);
    cur = 0;
    adv_to(5);
    check("rel_nopend_an", 32'(an), 32'hE);
    check("rel_nopend_seg", 32'(seg), 32'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
